// File: rtl/time_set_pkg.sv
// Shared types, BCD limits and increment helpers for the alarm-clock time-set front end.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EDIT_TIME  = 2'd1,
    EDIT_ALARM = 2'd2
  } state_e;

  localparam logic [1:0] HOUR_TENS_MAX       = 2'd2;
  localparam logic [3:0] HOUR_UNITS_MAX_AT_2 = 4'd3;
  localparam logic [2:0] MIN_TENS_MAX        = 3'd5;
  localparam logic [3:0] UNITS_MAX           = 4'd9;

  localparam int NUM_BTNS   = 5;
  localparam int BTN_MODE   = 0;
  localparam int BTN_HOUR   = 1;
  localparam int BTN_MIN    = 2;
  localparam int BTN_SET    = 3;
  localparam int BTN_SNOOZE = 4;

  // Returns {tens, units}; 23 wraps to 00.
  function automatic logic [5:0] hour_inc(input logic [1:0] tens, input logic [3:0] units);
    logic [5:0] r;
    if (tens == HOUR_TENS_MAX && units == HOUR_UNITS_MAX_AT_2) begin
      r = 6'd0;
    end else if (units == UNITS_MAX) begin
      r = {tens + 2'd1, 4'd0};
    end else begin
      r = {tens, units + 4'd1};
    end
    return r;
  endfunction

  // Returns {tens, units}; 59 wraps to 00 and never carries into the hour.
  function automatic logic [6:0] min_inc(input logic [2:0] tens, input logic [3:0] units);
    logic [6:0] r;
    if (units == UNITS_MAX) begin
      if (tens == MIN_TENS_MAX) begin
        r = 7'd0;
      end else begin
        r = {tens + 3'd1, 4'd0};
      end
    end else begin
      r = {tens, units + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle press pulse on the level's rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      // Flip on the DEBOUNCE_CYCLES-th consecutive differing cycle.
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Alarm-clock user-input front end: debounced buttons drive a mode FSM that edits a
// BCD hh:mm value and strobes it into the clock core as time or alarm.
//
//   state      | meaning
//   IDLE       | not editing; set toggles AL_ON
//   EDIT_TIME  | hour/min edit value; set strobes LD_time
//   EDIT_ALARM | hour/min edit value; set strobes LD_alarm
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_set,
  input  logic       btn_snooze,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [2:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] mode
);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] press;

  assign raw[BTN_MODE]   = btn_mode;
  assign raw[BTN_HOUR]   = btn_hour;
  assign raw[BTN_MIN]    = btn_min;
  assign raw[BTN_SET]    = btn_set;
  assign raw[BTN_SNOOZE] = btn_snooze;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (raw[i]),
      .press_o(press[i])
    );
  end

  state_e     state_q, state_d;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d;
  logic [2:0] m1_q, m1_d;
  logic [3:0] m0_q, m0_d;
  logic       ld_time_q, ld_time_d;
  logic       ld_alarm_q, ld_alarm_d;
  logic       stop_al_q, stop_al_d;
  logic       al_on_q, al_on_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      h1_q       <= '0;
      h0_q       <= '0;
      m1_q       <= '0;
      m0_q       <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      stop_al_q  <= 1'b0;
      al_on_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      m1_q       <= m1_d;
      m0_q       <= m0_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      stop_al_q  <= stop_al_d;
      al_on_q    <= al_on_d;
    end
  end

  // Priority: mode > set > hour/min; snooze is orthogonal to everything else.
  always_comb begin
    state_d    = state_q;
    h1_d       = h1_q;
    h0_d       = h0_q;
    m1_d       = m1_q;
    m0_d       = m0_q;
    ld_time_d  = 1'b0;
    ld_alarm_d = 1'b0;
    stop_al_d  = press[BTN_SNOOZE];
    al_on_d    = al_on_q;

    if (press[BTN_MODE]) begin
      case (state_q)
        IDLE:      state_d = EDIT_TIME;
        EDIT_TIME: state_d = EDIT_ALARM;
        default:   state_d = IDLE;
      endcase
    end else if (press[BTN_SET]) begin
      case (state_q)
        EDIT_TIME: begin
          ld_time_d = 1'b1;
          state_d   = IDLE;
        end
        EDIT_ALARM: begin
          ld_alarm_d = 1'b1;
          state_d    = IDLE;
        end
        default: al_on_d = ~al_on_q;
      endcase
    end else if (state_q != IDLE) begin
      if (press[BTN_HOUR]) begin
        {h1_d, h0_d} = hour_inc(h1_q, h0_q);
      end
      if (press[BTN_MIN]) begin
        {m1_d, m0_d} = min_inc(m1_q, m0_q);
      end
    end
  end

  assign H_in1    = h1_q;
  assign H_in0    = h0_q;
  assign M_in1    = m1_q;
  assign M_in0    = m0_q;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;
  assign STOP_al  = stop_al_q;
  assign AL_ON    = al_on_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: scripted vector table, reset corner cases, then random
// button traffic checked against an hh:mm integer model.
module tb_time_set_ctrl;

  localparam int DC      = 4;
  localparam int LATENCY = DC + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_hour, btn_min, btn_set, btn_snooze;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [2:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON;
  logic [1:0] mode;

  always #5 clk = ~clk;

  time_set_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_hour  (btn_hour),
    .btn_min   (btn_min),
    .btn_set   (btn_set),
    .btn_snooze(btn_snooze),
    .H_in1     (H_in1),
    .H_in0     (H_in0),
    .M_in1     (M_in1),
    .M_in0     (M_in0),
    .LD_time   (LD_time),
    .LD_alarm  (LD_alarm),
    .STOP_al   (STOP_al),
    .AL_ON     (AL_ON),
    .mode      (mode)
  );

  // btns bit order: [0] mode, [1] hour, [2] min, [3] set, [4] snooze
  typedef struct {
    logic [4:0] btns;
    int         hold;
    int         reps;
    int         exp_mode;
    int         exp_hour;
    int         exp_min;
    int         exp_al;
    int         n_ldt;
    int         n_lda;
    int         n_stp;
  } vec_t;

  int n_vec  = 0;
  int n_chk  = 0;
  int errs   = 0;

  int m_state, m_hour, m_min, m_al;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] b);
    btn_mode   = b[0];
    btn_hour   = b[1];
    btn_min    = b[2];
    btn_set    = b[3];
    btn_snooze = b[4];
  endtask

  function automatic int dut_hour();
    return int'(H_in1) * 10 + int'(H_in0);
  endfunction

  function automatic int dut_min();
    return int'(M_in1) * 10 + int'(M_in0);
  endfunction

  // Drive buttons for `hold` cycles, release, and observe strobes until everything settles.
  task automatic press_and_watch(input logic [4:0] b, input int hold,
                                 output int nldt, output int nlda, output int nstp,
                                 output int pldt, output int plda, output int pstp,
                                 output int nboth);
    nldt = 0; nlda = 0; nstp = 0; nboth = 0;
    pldt = -1; plda = -1; pstp = -1;
    @(negedge clk);
    drive(b);
    for (int i = 0; i < hold + 12; i++) begin
      @(posedge clk);
      #1;
      if (i == hold - 1) drive(5'b0);
      if (LD_time)  begin nldt++; if (pldt < 0) pldt = i; end
      if (LD_alarm) begin nlda++; if (plda < 0) plda = i; end
      if (STOP_al)  begin nstp++; if (pstp < 0) pstp = i; end
      if (LD_time && LD_alarm) nboth++;
    end
  endtask

  task automatic apply_and_check(input logic [4:0] b, input int hold,
                                 input int e_ldt, input int e_lda, input int e_stp,
                                 input int e_mode, input int e_hour, input int e_min,
                                 input int e_al, input string tag);
    int nldt, nlda, nstp, pldt, plda, pstp, nboth;
    press_and_watch(b, hold, nldt, nlda, nstp, pldt, plda, pstp, nboth);
    n_vec++;
    chk({tag, " ld_time_count"},  nldt, e_ldt);
    chk({tag, " ld_alarm_count"}, nlda, e_lda);
    chk({tag, " stop_al_count"},  nstp, e_stp);
    chk({tag, " ld_both"},        nboth, 0);
    if (e_ldt == 1) chk({tag, " ld_time_latency"},  pldt, LATENCY);
    if (e_lda == 1) chk({tag, " ld_alarm_latency"}, plda, LATENCY);
    if (e_stp == 1) chk({tag, " stop_al_latency"},  pstp, LATENCY);
    chk({tag, " mode"},  int'(mode), e_mode);
    chk({tag, " hour"},  dut_hour(), e_hour);
    chk({tag, " min"},   dut_min(),  e_min);
    chk({tag, " al_on"}, int'(AL_ON), e_al);
  endtask

  vec_t tbl[19];

  initial begin
    int nldt, nlda, nstp, pldt, plda, pstp, nboth;
    logic [4:0] b;
    int hold, e_ldt, e_lda, e_stp;
    bit pressed;

    tbl[0]  = '{5'b10000,  8,  1, 0,  0,  0, 0, 0, 0, 1};
    tbl[1]  = '{5'b00001,  8,  1, 1,  0,  0, 0, 0, 0, 0};
    tbl[2]  = '{5'b00010,  6, 24, 1,  0,  0, 0, 0, 0, 0};
    tbl[3]  = '{5'b00010,  6, 13, 1, 13,  0, 0, 0, 0, 0};
    tbl[4]  = '{5'b01000,  8,  1, 0, 13,  0, 0, 1, 0, 0};
    tbl[5]  = '{5'b00001,  8,  1, 1, 13,  0, 0, 0, 0, 0};
    tbl[6]  = '{5'b00100,  5, 58, 1, 13, 58, 0, 0, 0, 0};
    tbl[7]  = '{5'b00100,  5,  1, 1, 13, 59, 0, 0, 0, 0};
    tbl[8]  = '{5'b00100,  5,  1, 1, 13,  0, 0, 0, 0, 0};
    tbl[9]  = '{5'b00010,  3,  1, 1, 13,  0, 0, 0, 0, 0};
    tbl[10] = '{5'b00010, 20,  1, 1, 14,  0, 0, 0, 0, 0};
    tbl[11] = '{5'b00001,  8,  1, 2, 14,  0, 0, 0, 0, 0};
    tbl[12] = '{5'b01000,  8,  1, 0, 14,  0, 0, 0, 1, 0};
    tbl[13] = '{5'b00001,  8,  3, 0, 14,  0, 0, 0, 0, 0};
    tbl[14] = '{5'b01000,  8,  1, 0, 14,  0, 1, 0, 0, 0};
    tbl[15] = '{5'b01000,  8,  1, 0, 14,  0, 0, 0, 0, 0};
    tbl[16] = '{5'b00001,  8,  1, 1, 14,  0, 0, 0, 0, 0};
    tbl[17] = '{5'b01001,  8,  1, 2, 14,  0, 0, 0, 0, 0};
    tbl[18] = '{5'b00110,  8,  1, 2, 15,  1, 0, 0, 0, 0};

    drive(5'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mode",     int'(mode), 0);
    chk("reset hour",     dut_hour(), 0);
    chk("reset min",      dut_min(),  0);
    chk("reset ld_time",  int'(LD_time), 0);
    chk("reset ld_alarm", int'(LD_alarm), 0);
    chk("reset stop_al",  int'(STOP_al), 0);
    chk("reset al_on",    int'(AL_ON), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 19; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) begin
        // Intermediate reps of a repeated row only check strobes, not the final digits.
        if (r == tbl[v].reps - 1) begin
          apply_and_check(tbl[v].btns, tbl[v].hold, tbl[v].n_ldt, tbl[v].n_lda, tbl[v].n_stp,
                          tbl[v].exp_mode, tbl[v].exp_hour, tbl[v].exp_min, tbl[v].exp_al,
                          $sformatf("vec%0d", v));
        end else begin
          press_and_watch(tbl[v].btns, tbl[v].hold, nldt, nlda, nstp, pldt, plda, pstp, nboth);
          n_vec++;
          chk($sformatf("vec%0d rep%0d strobes", v, r), nldt + nlda + nstp, 0);
        end
      end
    end

    // Set press in EDIT_ALARM aborted by reset before it debounces.
    @(negedge clk);
    btn_set = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    btn_set = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nldt = 0; nlda = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (LD_time)  nldt++;
      if (LD_alarm) nlda++;
    end
    n_vec++;
    chk("abort ld_time",  nldt, 0);
    chk("abort ld_alarm", nlda, 0);
    chk("abort mode",     int'(mode), 0);
    chk("abort hour",     dut_hour(), 0);
    chk("abort min",      dut_min(),  0);
    chk("abort al_on",    int'(AL_ON), 0);

    m_state = 0; m_hour = 0; m_min = 0; m_al = 0;
    for (int n = 0; n < 150; n++) begin
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 3) == 0);
      hold    = $urandom_range(1, 10);
      pressed = (hold >= DC);
      e_ldt = 0; e_lda = 0; e_stp = 0;
      if (pressed) begin
        e_stp = b[4] ? 1 : 0;
        if (b[0]) begin
          m_state = (m_state + 1) % 3;
        end else if (b[3]) begin
          if (m_state == 1) e_ldt = 1;
          if (m_state == 2) e_lda = 1;
          if (m_state == 0) m_al = 1 - m_al;
          m_state = 0;
        end else if (m_state != 0) begin
          if (b[1]) m_hour = (m_hour + 1) % 24;
          if (b[2]) m_min  = (m_min + 1) % 60;
        end
      end
      apply_and_check(b, hold, e_ldt, e_lda, e_stp, m_state, m_hour, m_min, m_al,
                      $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
    $finish;
  end

endmodule
